instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage, directly upstream of control_unit.
//  - Holds the PC and issues word reads to instruction memory over a req/ack handshake.
//  - Buffers returned words, tagged with their PC, in a DEPTH-entry FIFO.
//  - Presents the FIFO head to the decoder over a valid/ready handshake.
//  - Supports PC redirect (branch/jump) with flush, including discard of an in-flight read.
// PARAMETERS
//  ADDR_W    32     PC / memory address width
//  RESET_PC  0      PC loaded on reset (word aligned)
//  DEPTH     4      instruction buffer entries; power of two, >= 2
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst             in   1       synchronous, active-high reset
//  imem_req        out  1       read request to instruction memory
//  imem_addr       out  ADDR_W  read address; stable while imem_req=1
//  imem_ack        in   1       read data valid this cycle (only meaningful when imem_req=1)
//  imem_rdata      in   32      instruction word returned with imem_ack
//  redirect_valid  in   1       load new PC, flush buffer
//  redirect_pc     in   ADDR_W  redirect target; bits [1:0] ignored (forced 0)
//  instr_valid     out  1       instruction/instr_pc valid (buffer not empty)
//  instr_ready     in   1       decoder accepts head entry
//  instruction     out  32      head instruction word, to control_unit
//  instr_pc        out  ADDR_W  PC of head instruction
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state IDLE; pc=RESET_PC; FIFO empty; storage cleared.
//   Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0.
//   Reset mid-request: the outstanding read is abandoned; memory must tolerate req drop.
//  FSM (state registered; imem_req = (state==REQ || state==DRAIN); imem_addr = pc):
//   IDLE  -> REQ when count<DEPTH, else stay.
//   REQ, ack=0 -> REQ (req and addr held).
//   REQ, ack=1 -> push {pc,rdata}; pc+=4.
//     Next: REQ if (count+1-pop)<DEPTH, else IDLE.
//   DRAIN: entered on redirect while REQ and ack=0.
//     Holds old addr until ack; returned data discarded.
//     On ack: pc=pending target. Next state REQ if count<DEPTH, else IDLE.
//  Redirect (highest priority; beats push, pop and space checks):
//   - FIFO flushed (count=0); no pop is counted that cycle.
//   - IDLE, or REQ with ack=1: data dropped; pc=redirect_pc; next state REQ.
//   - REQ with ack=0: target saved as pending; pc unchanged; next state DRAIN.
//   - DRAIN: pending target overwritten. If ack=1 that cycle: pc=new target; next state REQ.
//  Throughput/latency:
//   - Single-cycle-ack memory sustains 1 instr/cycle.
//   - instr_valid rises the cycle after the ack edge.
//   - First imem_req is the cycle after rst deasserts.
//  FIFO:
//   - pop = instr_valid && instr_ready.
//   - Push and pop in the same cycle allowed when full (count unchanged).
//   - instr_valid = (count!=0); instruction/instr_pc driven from head storage.
//   - At most one memory request outstanding, so occupancy never exceeds DEPTH.
//  Arithmetic: pc increments by 4 modulo 2^ADDR_W (0x...FFFC wraps to 0). Pointers wrap modulo DEPTH.
//  While instr_valid=1 and instr_ready=0, instruction and instr_pc are held stable.
// TESTING
//  1. Reset, ack always 1, ready=1:
//     -> addr 0,4,8,... one per cycle; instr_valid from cycle 2; instr_pc matches rdata order.
//  2. ready=0, DEPTH=4, ack=1:
//     -> exactly 4 pushes, then imem_req=0.
//     ready=1 for one cycle -> 1 pop, one new request, PCs contiguous.
//  3. Redirect to 0x100 while REQ with ack delayed 3 cycles:
//     -> DRAIN holds old addr; that data not delivered; next addr 0x100; first instr_pc=0x100.
//  4. redirect_valid with ack=1 and a pop in the same cycle:
//     -> FIFO empty next cycle, acked word dropped, imem_addr=redirect_pc.
//  5. RESET_PC=0xFFFFFFF8, ADDR_W=32 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
//  6. rst asserted mid-DRAIN with 2 entries buffered
//     -> next cycle all outputs at reset values; refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding control_unit.
//   Holds the PC and reads instruction memory one word at a time over a req/ack handshake.
//   Returned words, tagged with their PC, are queued in a DEPTH-entry buffer and presented
//   to the decoder over valid/ready. A redirect loads a new PC and flushes the buffer. If a
//   read is in flight when the redirect arrives, that read is drained and its data dropped.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   imem_req/imem_addr  read request and word address (addr = PC, stable while req=1)
//   imem_ack/imem_rdata read completion and returned word
//   redirect_valid/pc   branch/jump target (bits [1:0] forced to zero)
//   instr_valid/ready   decoder handshake for the buffer head
//   instruction/instr_pc head word and its PC
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wr_q, wr_d;
  logic [PtrW-1:0]   rd_q, rd_d;
  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];

  logic              push, pop, flush;
  logic [ADDR_W-1:0] redir_tgt;
  logic [CntW-1:0]   cnt_after;

  assign redir_tgt = redirect_pc & ~ADDR_W'(3);
  assign pop       = instr_valid && instr_ready;
  // Occupancy after this cycle's push and pop; only used in StReq where count < DEPTH.
  assign cnt_after = cnt_q + CntW'(1) - CntW'(pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      // Redirect wins over everything: flush, and drop any word arriving this cycle.
      flush = 1'b1;
      unique case (state_q)
        StIdle: begin
          pc_d    = redir_tgt;
          state_d = StReq;
        end
        StReq: begin
          if (imem_ack) begin
            pc_d    = redir_tgt;
            state_d = StReq;
          end else begin
            // Read still outstanding: keep old address until it completes.
            pend_d  = redir_tgt;
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (imem_ack) begin
            pc_d    = redir_tgt;
            state_d = StReq;
          end else begin
            pend_d = redir_tgt;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cnt_q < DepthC) state_d = StReq;
        end
        StReq: begin
          if (imem_ack) begin
            push    = 1'b1;
            pc_d    = pc_q + ADDR_W'(4);
            state_d = (cnt_after < DepthC) ? StReq : StIdle;
          end
        end
        StDrain: begin
          if (imem_ack) begin
            pc_d    = pend_q;
            state_d = (cnt_q < DepthC) ? StReq : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    if (flush) begin
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end else begin
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
      wr_d  = push ? wr_q + PtrW'(1) : wr_q;
      rd_d  = pop  ? rd_q + PtrW'(1) : rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (push) begin
        data_q[wr_q] <= imem_rdata;
        tag_q[wr_q]  <= pc_q;
      end
    end
  end

  assign imem_req    = (state_q == StReq) || (state_q == StDrain);
  assign imem_addr   = pc_q;
  assign instr_valid = (cnt_q != '0);
  assign instruction = data_q[rd_q];
  assign instr_pc    = tag_q[rd_q];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  instr_fetch #(
    .ADDR_W  (32),
    .RESET_PC(32'h0),
    .DEPTH   (Depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Directed vectors: inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic        rst, ack, rdy, rdr;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int unsigned r, input int unsigned a, input int unsigned y,
                     input int unsigned d, input logic [31:0] rpc, input int unsigned q,
                     input logic [31:0] addr, input int unsigned v, input logic [31:0] ipc);
    vec_t t;
    t.rst = (r != 0); t.ack = (a != 0); t.rdy = (y != 0); t.rdr = (d != 0);
    t.rpc = rpc; t.req = (q != 0); t.addr = addr; t.vld = (v != 0); t.ipc = ipc;
    vq.push_back(t);
  endtask

  // Reference model: a queue of fetched {pc, word}, the next fetch PC, whether a read is
  // being issued, and whether the issued read is a stale one to be thrown away.
  logic [31:0] m_qpc[$];
  logic [31:0] m_qw[$];
  logic [31:0] m_pc, m_pend;
  bit          m_act, m_disc;

  task automatic model_step(input bit r, input bit ack, input bit rdy, input bit rdr,
                            input logic [31:0] rpc);
    int          cnt0;
    logic [31:0] tgt;
    if (r) begin
      m_qpc.delete(); m_qw.delete();
      m_pc = 32'h0; m_pend = 32'h0; m_act = 0; m_disc = 0;
      return;
    end
    cnt0 = m_qpc.size();
    tgt  = rpc & ~32'h3;
    if (rdr) begin
      m_qpc.delete(); m_qw.delete();
      if (!m_act) begin
        m_pc = tgt; m_act = 1;
      end else if (m_disc) begin
        if (ack) begin m_pc = tgt; m_disc = 0; end
        else m_pend = tgt;
      end else if (ack) begin
        m_pc = tgt;
      end else begin
        m_disc = 1; m_pend = tgt;
      end
    end else begin
      if (cnt0 > 0 && rdy) begin
        void'(m_qpc.pop_front()); void'(m_qw.pop_front());
      end
      if (!m_act) begin
        m_act = (cnt0 < Depth);
      end else if (m_disc) begin
        if (ack) begin m_pc = m_pend; m_disc = 0; m_act = (cnt0 < Depth); end
      end else if (ack) begin
        m_qpc.push_back(m_pc); m_qw.push_back(mem_word(m_pc));
        m_pc  = m_pc + 32'd4;
        m_act = (m_qpc.size() < Depth);
      end
    end
  endtask

  initial begin
    logic [31:0] cur;
    bit          r_rst, r_ack, r_rdy, r_rdr;
    logic [31:0] r_pc;

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    //  rst ack rdy rdr rpc            req addr           vld ipc
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0);        // reset
    add(0, 1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0);        // first req
    add(0, 1, 1, 0, 32'h0,        1, 32'h4,        1, 32'h0);
    add(0, 1, 1, 0, 32'h0,        1, 32'h8,        1, 32'h4);
    add(0, 1, 1, 0, 32'h0,        1, 32'hC,        1, 32'h8);
    add(0, 1, 0, 0, 32'h0,        1, 32'h10,       1, 32'h8);        // stall: fill
    add(0, 1, 0, 0, 32'h0,        1, 32'h14,       1, 32'h8);
    add(0, 1, 0, 0, 32'h0,        0, 32'h18,       1, 32'h8);        // full
    add(0, 1, 0, 0, 32'h0,        0, 32'h18,       1, 32'h8);
    add(0, 1, 1, 0, 32'h0,        0, 32'h18,       1, 32'hC);        // one pop
    add(0, 1, 0, 0, 32'h0,        1, 32'h18,       1, 32'hC);
    add(0, 1, 0, 0, 32'h0,        0, 32'h1C,       1, 32'hC);
    add(0, 0, 1, 0, 32'h0,        0, 32'h1C,       1, 32'h10);
    add(0, 0, 0, 0, 32'h0,        1, 32'h1C,       1, 32'h10);
    add(0, 1, 1, 1, 32'h200,      1, 32'h200,      0, 32'h0);        // redir+ack+pop
    add(0, 0, 1, 0, 32'h0,        1, 32'h200,      0, 32'h0);
    add(0, 0, 1, 1, 32'h101,      1, 32'h200,      0, 32'h0);        // -> drain
    add(0, 0, 1, 0, 32'h0,        1, 32'h200,      0, 32'h0);
    add(0, 0, 1, 0, 32'h0,        1, 32'h200,      0, 32'h0);
    add(0, 1, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0);        // stale dropped
    add(0, 1, 0, 0, 32'h0,        1, 32'h104,      1, 32'h100);
    add(0, 1, 1, 1, 32'hFFFFFFF8, 1, 32'hFFFFFFF8, 0, 32'h0);        // wrap
    add(0, 1, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 32'hFFFFFFF8);
    add(0, 1, 1, 0, 32'h0,        1, 32'h0,        1, 32'hFFFFFFFC);
    add(0, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'hFFFFFFFC);
    add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);        // reset mid-req
    add(0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 0, 0, 1, 32'h40,       1, 32'h0,        0, 32'h0);        // drain
    add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);        // reset mid-drain
    add(0, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0);
    add(0, 0, 0, 1, 32'h80,       1, 32'h4,        0, 32'h0);        // drain
    add(0, 1, 0, 1, 32'h90,       1, 32'h90,       0, 32'h0);        // re-redir + ack
    add(0, 1, 0, 0, 32'h0,        1, 32'h94,       1, 32'h90);
    add(0, 1, 0, 0, 32'h0,        1, 32'h98,       1, 32'h90);
    add(0, 1, 0, 0, 32'h0,        1, 32'h9C,       1, 32'h90);
    add(0, 1, 0, 0, 32'h0,        0, 32'hA0,       1, 32'h90);        // full, idle
    add(0, 0, 0, 1, 32'h300,      1, 32'h300,      0, 32'h0);        // redirect in idle

    cur = 32'h0;
    foreach (vq[i]) begin
      rst = vq[i].rst; imem_ack = vq[i].ack; instr_ready = vq[i].rdy;
      redirect_valid = vq[i].rdr; redirect_pc = vq[i].rpc; imem_rdata = mem_word(cur);
      @(posedge clk);
      #1;
      check($sformatf("v%0d req", i), {31'b0, imem_req}, {31'b0, vq[i].req});
      check($sformatf("v%0d addr", i), imem_addr, vq[i].addr);
      check($sformatf("v%0d valid", i), {31'b0, instr_valid}, {31'b0, vq[i].vld});
      if (vq[i].vld || vq[i].rst) begin
        check($sformatf("v%0d instr_pc", i), instr_pc, vq[i].ipc);
        check($sformatf("v%0d instruction", i), instruction,
              vq[i].rst ? 32'h0 : mem_word(vq[i].ipc));
      end
      cur = vq[i].addr;
    end

    // Randomised run against the model, starting from reset.
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 249) == 0);
      r_ack = ($urandom_range(0, 9) < 7);
      r_rdy = ($urandom_range(0, 9) < (((i / 400) % 2 == 1) ? 2 : 8));
      r_rdr = ($urandom_range(0, 24) == 0);
      r_pc  = $urandom;
      if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
      rst = r_rst; imem_ack = r_ack; instr_ready = r_rdy;
      redirect_valid = r_rdr; redirect_pc = r_pc; imem_rdata = mem_word(m_pc);
      @(posedge clk);
      model_step(r_rst, r_ack, r_rdy, r_rdr, r_pc);
      #1;
      check($sformatf("r%0d req", i), {31'b0, imem_req}, {31'b0, m_act});
      check($sformatf("r%0d addr", i), imem_addr, m_pc);
      check($sformatf("r%0d valid", i), {31'b0, instr_valid}, {31'b0, m_qpc.size() != 0});
      if (m_qpc.size() != 0) begin
        check($sformatf("r%0d instr_pc", i), instr_pc, m_qpc[0]);
        check($sformatf("r%0d instruction", i), instruction, m_qw[0]);
      end else if (r_rst) begin
        check($sformatf("r%0d rst instr_pc", i), instr_pc, 32'h0);
        check($sformatf("r%0d rst instruction", i), instruction, 32'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
